// File: rtl/hazard_redirect_ctrl.sv
// hazard_redirect_ctrl
// Front-end hazard and redirect control for the IF/ID boundary. Decodes the
// instruction in ID, compares its sources against the EX load destination,
// and chooses between branch redirect, load-use replay, halt freeze or
// normal flow. A small FSM covers the boot redirect and the one-cycle squash
// that follows every redirect. Event counters saturate at all-ones.
module hazard_redirect_ctrl #(
  parameter logic [15:0] BOOT_PC = 16'h0000,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic [15:0]      pc_D,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic [15:0]      ex_branch_target,
  input  logic             halt_req,
  output logic             pc_src,
  output logic [15:0]      dest_pc,
  output logic             pc_write_zero,
  output logic             IFID_pipeline_write_zero,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] halt_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_load_use;
  logic             w_inc_stall;
  logic             w_inc_flush;
  logic             w_inc_halt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_halt_cnt;

  wire [6:0] w_opcode = instr_D[6:0];
  wire [4:0] w_rs1    = instr_D[19:15];
  wire [4:0] w_rs2    = instr_D[24:20];

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Decode which source registers the ID instruction actually reads.
  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      7'b0100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      7'b1100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
      7'b0010011: w_uses_rs1 = 1'b1;
      7'b0000011: w_uses_rs1 = 1'b1;
      7'b1100111: w_uses_rs1 = 1'b1;
      default: begin w_uses_rs1 = 1'b0; w_uses_rs2 = 1'b0; end
    endcase
  end

  assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((w_uses_rs1 && (ex_rd == w_rs1)) ||
                       (w_uses_rs2 && (ex_rd == w_rs2)));

  // Next-state and prioritised control outputs (redirect > replay > halt).
  always_comb begin
    w_next                   = r_state;
    pc_src                   = 1'b0;
    dest_pc                  = 16'h0000;
    pc_write_zero            = 1'b0;
    IFID_pipeline_write_zero = 1'b0;
    idex_flush               = 1'b0;
    w_inc_stall              = 1'b0;
    w_inc_flush              = 1'b0;
    w_inc_halt               = 1'b0;
    if (reset) begin
      // Bubbles into both stages while held in reset; no PC movement.
      IFID_pipeline_write_zero = 1'b1;
      idex_flush               = 1'b1;
      w_next                   = ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: begin
          pc_src                   = 1'b1;
          dest_pc                  = BOOT_PC;
          IFID_pipeline_write_zero = 1'b1;
          idex_flush               = 1'b1;
          w_next                   = ST_SQUASH;
        end
        ST_RUN: begin
          if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            pc_src                   = 1'b1;
            dest_pc                  = ex_branch_target;
            IFID_pipeline_write_zero = 1'b1;
            idex_flush               = 1'b1;
            w_inc_flush              = 1'b1;
            w_next                   = ST_SQUASH;
          end else if (w_load_use) begin
            // Replay: refetch the dependent instruction two cycles later.
            pc_src                   = 1'b1;
            dest_pc                  = pc_D;
            IFID_pipeline_write_zero = 1'b1;
            idex_flush               = 1'b1;
            w_inc_stall              = 1'b1;
            w_next                   = ST_SQUASH;
          end else if (halt_req) begin
            pc_write_zero            = 1'b1;
            IFID_pipeline_write_zero = 1'b1;
            w_inc_halt               = 1'b1;
            w_next                   = ST_RUN;
          end else begin
            w_next                   = ST_RUN;
          end
        end
        ST_SQUASH: begin
          // EX and ID hold bubbles here; only a halt can act.
          w_next = ST_RUN;
          if (halt_req) begin
            pc_write_zero            = 1'b1;
            IFID_pipeline_write_zero = 1'b1;
            w_inc_halt               = 1'b1;
          end else begin
            pc_write_zero            = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: bubble the pipe and restart via BOOT.
          IFID_pipeline_write_zero = 1'b1;
          idex_flush               = 1'b1;
          w_next                   = ST_BOOT;
        end
      endcase
    end
  end

  // State register; reset forces BOOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
      r_halt_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_inc_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_inc_flush) r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_inc_halt)  r_halt_cnt  <= sat_inc(r_halt_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign halt_cnt  = r_halt_cnt;

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Testbench for hazard_redirect_ctrl: directed scenarios followed by random
// stimulus, all checked against a cycle-level reference model. Two instances
// share the stimulus: a wide-counter one and a 2-bit-counter one.
module tb_hazard_redirect_ctrl;

  localparam logic [15:0] BOOT = 16'h0040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_D = 32'h0;
  logic [15:0] pc_D = 16'h0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_branch_taken = 1'b0;
  logic [15:0] ex_branch_target = 16'h0;
  logic        halt_req = 1'b0;

  logic        a_pc_src, a_pwz, a_ifid, a_idex;
  logic [15:0] a_dest;
  logic [15:0] a_stall, a_flush, a_halt;
  logic        b_pc_src, b_pwz, b_ifid, b_idex;
  logic [15:0] b_dest;
  logic [1:0]  b_stall, b_flush, b_halt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_boot = 1'b1;   // next cycle is the first one after reset
  bit m_sq   = 1'b0;   // previous cycle issued a redirect
  int m_stall = 0, m_flush = 0, m_halt = 0;

  always #5 clk = ~clk;

  hazard_redirect_ctrl #(.BOOT_PC(BOOT), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .instr_D(instr_D), .pc_D(pc_D),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .halt_req(halt_req), .pc_src(a_pc_src), .dest_pc(a_dest),
    .pc_write_zero(a_pwz), .IFID_pipeline_write_zero(a_ifid),
    .idex_flush(a_idex), .stall_cnt(a_stall), .flush_cnt(a_flush),
    .halt_cnt(a_halt)
  );

  hazard_redirect_ctrl #(.BOOT_PC(BOOT), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .instr_D(instr_D), .pc_D(pc_D),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .halt_req(halt_req), .pc_src(b_pc_src), .dest_pc(b_dest),
    .pc_write_zero(b_pwz), .IFID_pipeline_write_zero(b_ifid),
    .idex_flush(b_idex), .stall_cnt(b_stall), .flush_cnt(b_flush),
    .halt_cnt(b_halt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Does the ID instruction read a register the EX load is writing?
  function automatic bit model_load_use(input logic [31:0] ins, input bit rd_ld,
                                        input logic [4:0] rd);
    logic [6:0] op;
    bit r1, r2;
    op = ins[6:0];
    r1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1100111};
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (!rd_ld || rd == 5'd0) return 1'b0;
    return (r1 && rd == ins[19:15]) || (r2 && rd == ins[24:20]);
  endfunction

  // One clock: drive inputs after the edge, compare against the model, then
  // advance the model across the coming edge.
  task automatic run_cyc(input bit rst, input logic [31:0] ins,
                         input logic [15:0] pc, input bit ld,
                         input logic [4:0] rd, input bit br,
                         input logic [15:0] tgt, input bit hlt);
    bit e_src, e_pwz, e_ifid, e_idex, lu, redirect;
    logic [15:0] e_dest;
    @(posedge clk);
    #1;
    reset = rst; instr_D = ins; pc_D = pc; ex_mem_read = ld; ex_rd = rd;
    ex_branch_taken = br; ex_branch_target = tgt; halt_req = hlt;
    #1;
    // Counters reflect everything up to the edge just passed.
    check_val("stall_a", {16'h0, a_stall}, sat(m_stall, 16));
    check_val("flush_a", {16'h0, a_flush}, sat(m_flush, 16));
    check_val("halt_a",  {16'h0, a_halt},  sat(m_halt, 16));
    check_val("stall_b", {30'h0, b_stall}, sat(m_stall, 2));
    check_val("flush_b", {30'h0, b_flush}, sat(m_flush, 2));
    check_val("halt_b",  {30'h0, b_halt},  sat(m_halt, 2));
    e_src = 0; e_pwz = 0; e_ifid = 0; e_idex = 0; e_dest = 16'h0;
    redirect = 0;
    lu = model_load_use(ins, ld, rd);
    if (rst) begin
      e_ifid = 1; e_idex = 1;
    end else if (m_boot) begin
      e_src = 1; e_dest = BOOT; e_ifid = 1; e_idex = 1; redirect = 1;
    end else if (!m_sq && br) begin
      e_src = 1; e_dest = tgt; e_ifid = 1; e_idex = 1; redirect = 1;
      m_flush++;
    end else if (!m_sq && lu) begin
      e_src = 1; e_dest = pc; e_ifid = 1; e_idex = 1; redirect = 1;
      m_stall++;
    end else if (hlt) begin
      e_pwz = 1; e_ifid = 1;
      m_halt++;
    end
    check_val("pc_src_a", {31'h0, a_pc_src}, {31'h0, e_src});
    check_val("dest_a",   {16'h0, a_dest},   {16'h0, e_dest});
    check_val("pwz_a",    {31'h0, a_pwz},    {31'h0, e_pwz});
    check_val("ifid_a",   {31'h0, a_ifid},   {31'h0, e_ifid});
    check_val("idex_a",   {31'h0, a_idex},   {31'h0, e_idex});
    check_val("outs_b", {b_pc_src, b_pwz, b_ifid, b_idex, b_dest},
                        {e_src, e_pwz, e_ifid, e_idex, e_dest});
    if (rst) begin
      m_boot = 1; m_sq = 0; m_stall = 0; m_flush = 0; m_halt = 0;
    end else begin
      m_boot = 0; m_sq = redirect;
    end
  endtask

  task automatic idle();
    run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 0, 16'h0, 0);
  endtask

  localparam logic [31:0] ADD = 32'h00A28333;  // add x6,x5,x10
  localparam logic [31:0] LUI = 32'h000502B7;  // lui x5

  initial begin
    logic [6:0] ops [8];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b0110111, 7'b0000000};

    // Reset, then boot redirect and squash.
    run_cyc(1, 32'h0, 16'h0, 0, 5'd0, 0, 16'h0, 0);
    run_cyc(1, 32'h0, 16'h0, 0, 5'd0, 0, 16'h0, 0);
    idle();
    check_val("boot_src", {31'h0, a_pc_src}, 32'd1);
    check_val("boot_dest", {16'h0, a_dest}, 32'h0040);
    idle();
    check_val("sq_ifid", {31'h0, a_ifid}, 32'd0);
    idle();

    // Load-use replay, then the same stimulus during SQUASH does nothing.
    run_cyc(0, ADD, 16'h0010, 1, 5'd5, 0, 16'h0, 0);
    check_val("lu_dest", {16'h0, a_dest}, 32'h0010);
    check_val("lu_idex", {31'h0, a_idex}, 32'd1);
    run_cyc(0, ADD, 16'h0010, 1, 5'd5, 0, 16'h0, 0);
    check_val("lu_sq_src", {31'h0, a_pc_src}, 32'd0);
    check_val("lu_cnt", {16'h0, a_stall}, 32'd1);

    // No-stall cases.
    run_cyc(0, ADD, 16'h0014, 1, 5'd0, 0, 16'h0, 0);
    run_cyc(0, ADD, 16'h0014, 0, 5'd5, 0, 16'h0, 0);
    run_cyc(0, LUI, 16'h0014, 1, 5'd0, 0, 16'h0, 0);
    check_val("lui_src", {31'h0, a_pc_src}, 32'd0);

    // Branch beats load-use.
    run_cyc(0, ADD, 16'h0018, 1, 5'd5, 1, 16'h0080, 0);
    check_val("br_dest", {16'h0, a_dest}, 32'h0080);
    idle();
    check_val("br_flush", {16'h0, a_flush}, 32'd1);
    check_val("br_stall", {16'h0, a_stall}, 32'd1);

    // Three halt cycles in RUN.
    repeat (3) run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 0, 16'h0, 1);
    idle();
    check_val("halt3", {16'h0, a_halt}, 32'd3);

    // Branch with halt: redirect first, freeze during SQUASH.
    run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 1, 16'h0100, 1);
    check_val("brh_pwz", {31'h0, a_pwz}, 32'd0);
    run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 1, 16'h0100, 1);
    check_val("brh_sq_pwz", {31'h0, a_pwz}, 32'd1);
    idle();

    // Five separated branches saturate the 2-bit flush counter.
    repeat (5) begin
      run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 1, 16'h0200, 0);
      idle();
      idle();
    end
    check_val("sat_flush_b", {30'h0, b_flush}, 32'd3);

    // Reset asserted during SQUASH.
    run_cyc(0, 32'h0, 16'h0, 0, 5'd0, 1, 16'h0300, 0);
    run_cyc(1, 32'h0, 16'h0, 0, 5'd0, 1, 16'h0300, 0);
    idle();
    check_val("rst_boot_dest", {16'h0, a_dest}, 32'h0040);
    check_val("rst_flush", {16'h0, a_flush}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      run_cyc(($urandom_range(0, 99) == 0), ins, 16'($urandom),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
              $urandom_range(0, 5) == 0, 16'($urandom),
              $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
